// File: rtl/wb_host.sv
`default_nettype none
// ============================================================================
// Module   : wb_host
// Purpose  : Single-outstanding command host for a four-phase strobe/ack
//            register bus. One command is accepted in IDLE, driven onto the
//            bus, held through an acknowledge window of ACK_HOLD cycles,
//            released, and answered with a one-cycle response pulse.
// Ports    : clk, reset                      - clock, sync active-high reset
//            cmd_valid/ready/read/addr/wdata - command handshake
//            rsp_valid/rdata/err             - one-cycle response
//            wb_addr/data_out/data_in/we     - bus address, data, direction
//            wb_clk/stb/ack                  - bus phase strobe, select, ack
// Options  : WB_HOST_TIMEOUT_EN - enables the 8-bit ack watchdog; when it is
//            undefined rsp_err is tied low and REQ/RELEASE wait forever.
// Revision : 1.0 - initial release
// ============================================================================
module wb_host #(
  parameter int ACK_HOLD       = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic [1:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [1:0] wb_addr,
  output logic [7:0] wb_data_out,
  input  logic [7:0] wb_data_in,
  output logic       wb_we,
  output logic       wb_clk,
  output logic       wb_stb,
  input  logic       wb_ack
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_HOLD    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [3:0] HOLD_LAST = 4'(ACK_HOLD - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [1:0] wb_addr_q, wb_addr_d;
  logic [7:0] wb_data_q, wb_data_d;
  logic       wb_we_q, wb_we_d;
  logic       wb_clk_q, wb_clk_d;
  logic       wb_stb_q, wb_stb_d;
  logic       timeout_hit;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_valid_d = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_we_d     = wb_we_q;
    wb_clk_d    = wb_clk_q;
    wb_stb_d    = wb_stb_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          wb_addr_d = cmd_addr;
          // Reads put zero on the data bus rather than stale write data.
          wb_data_d = cmd_read ? 8'h00 : cmd_wdata;
          wb_we_d   = cmd_read;
          wb_stb_d  = 1'b1;
          wb_clk_d  = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        // Level-sensitive: an ack that is already high counts immediately.
        if (wb_ack) begin
          hold_cnt_d = 4'd0;
          state_d    = S_HOLD;
        end else if (timeout_hit) begin
          wb_clk_d = 1'b0;
          state_d  = S_RELEASE;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          if (wb_we_q) begin
            rsp_rdata_d = wb_data_in;
          end
          hold_cnt_d = 4'd0;
          wb_clk_d   = 1'b0;
          state_d    = S_RELEASE;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      S_RELEASE: begin
        if (!wb_ack || timeout_hit) begin
          wb_stb_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= 4'd0;
      rsp_rdata_q <= 8'h00;
      rsp_valid_q <= 1'b0;
      wb_addr_q   <= 2'd0;
      wb_data_q   <= 8'h00;
      wb_we_q     <= 1'b1;
      wb_clk_q    <= 1'b0;
      wb_stb_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_valid_q <= rsp_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      wb_we_q     <= wb_we_d;
      wb_clk_q    <= wb_clk_d;
      wb_stb_q    <= wb_stb_d;
    end
  end

`ifdef WB_HOST_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] to_cnt_q, to_cnt_d;
  logic       to_flag_q, to_flag_d;
  logic       rsp_err_q, rsp_err_d;
  logic       waiting;

  assign waiting     = (state_q == S_REQ) || (state_q == S_RELEASE);
  assign timeout_hit = waiting && (to_cnt_q == TO_LAST);

  always_comb begin
    // Counts cycles spent in the current wait state; any state change clears.
    to_cnt_d  = (waiting && (state_d == state_q)) ? to_cnt_q + 8'd1 : 8'd0;
    to_flag_d = to_flag_q;
    rsp_err_d = 1'b0;
    if (state_q == S_IDLE) begin
      to_flag_d = 1'b0;
    end
    if (timeout_hit) begin
      to_flag_d = 1'b1;
    end
    // rsp_err is only meaningful alongside the rsp_valid pulse.
    if (rsp_valid_d) begin
      rsp_err_d = to_flag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q  <= 8'd0;
      to_flag_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  assign cmd_ready   = (state_q == S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data_out = wb_data_q;
  assign wb_we       = wb_we_q;
  assign wb_clk      = wb_clk_q;
  assign wb_stb      = wb_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_host
// Purpose  : Self-checking bench for wb_host. A delay-programmable responder
//            drives wb_ack; expected latency, read data and bus contents come
//            from the transaction rules (delays + ACK_HOLD arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_host;

  localparam int H = 2;
  localparam int T = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_read = 1'b0;
  logic [1:0] cmd_addr = 2'd0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [1:0] wb_addr;
  logic [7:0] wb_data_out;
  logic [7:0] wb_data_in;
  logic       wb_we;
  logic       wb_clk;
  logic       wb_stb;
  logic       wb_ack;

  int passed = 0;
  int checks = 0;

  // Responder controls
  int         rise_dly = 1;
  int         fall_dly = 1;
  logic       stuck_lo = 1'b0;
  logic       stuck_hi = 1'b0;
  logic [7:0] rd_val = 8'h00;
  int         rcnt;

  // Reference state: last read data successfully returned
  logic [7:0] model_rdata = 8'h00;

  wb_host #(.ACK_HOLD(H), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_addr(wb_addr), .wb_data_out(wb_data_out), .wb_data_in(wb_data_in),
    .wb_we(wb_we), .wb_clk(wb_clk), .wb_stb(wb_stb), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  // Read data is only valid while ack is high; otherwise show its inverse.
  assign wb_data_in = wb_ack ? rd_val : ~rd_val;

  // Ack rises rise_dly cycles after seeing stb&clk, falls fall_dly cycles
  // after seeing clk low.
  always @(posedge clk) begin
    if (reset) begin
      wb_ack <= 1'b0;
      rcnt   <= 0;
    end else if (!wb_ack) begin
      if (wb_stb && wb_clk && !stuck_lo) begin
        if (rcnt + 1 >= rise_dly) begin wb_ack <= 1'b1; rcnt <= 0; end
        else rcnt <= rcnt + 1;
      end else rcnt <= 0;
    end else begin
      if (!wb_clk && !stuck_hi) begin
        if (rcnt + 1 >= fall_dly) begin wb_ack <= 1'b0; rcnt <= 0; end
        else rcnt <= rcnt + 1;
      end else rcnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int norm_lat(input int r, input int f);
    return r + 1 + H + f + 1;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk(tag, {cmd_ready, rsp_valid, rsp_err, rsp_rdata, wb_stb, wb_clk, wb_we, wb_addr, wb_data_out},
        {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00});
  endtask

  // Issue one command (called #1 after a posedge with the DUT idle) and
  // follow it through to the cycle after its response.
  task automatic run_txn(input string tag, input logic rd, input logic [1:0] a,
                         input logic [7:0] wd, input logic hold, input int lat,
                         input logic exp_err);
    logic [7:0] exp_rd;
    logic       prev_stb;
    int         got;
    int         stb_rises;
    int         clk_hi;
    bit         ack_seen;
    bit         bus_ok;
    bit         rdy_ok;
    got = -1; stb_rises = 0; clk_hi = 0; ack_seen = 0; bus_ok = 1; rdy_ok = 1;
    prev_stb = 1'b0;
    exp_rd = (rd && !exp_err) ? rd_val : model_rdata;
    chk({tag, ".ready_before"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd;
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    // Scrambled command fields must not reach the bus after acceptance.
    cmd_read = ~rd; cmd_addr = ~a; cmd_wdata = ~wd;
    for (int n = 0; n < lat + 40 && got < 0; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (wb_stb && !prev_stb) stb_rises++;
      prev_stb = wb_stb;
      if (wb_stb && (wb_addr !== a || wb_we !== rd || wb_data_out !== (rd ? 8'h00 : wd)))
        bus_ok = 0;
      if (cmd_ready !== 1'b0) rdy_ok = 0;
      if (ack_seen && wb_clk) clk_hi++;
      if (wb_ack) ack_seen = 1;
      if (rsp_valid === 1'b1) begin
        got = n;
        cmd_valid = 1'b0;
        chk({tag, ".rdata"}, rsp_rdata, exp_rd);
        chk({tag, ".err"}, rsp_err, exp_err);
        chk({tag, ".stb_low_at_rsp"}, wb_stb, 0);
      end
    end
    cmd_valid = 1'b0;
    chk({tag, ".latency"}, got, lat);
    chk({tag, ".bus_stable"}, bus_ok, 1);
    chk({tag, ".ready_low_busy"}, rdy_ok, 1);
    chk({tag, ".one_bus_txn"}, stb_rises, 1);
    chk({tag, ".clk_hold"}, clk_hi, stuck_lo ? 0 : H);
    @(posedge clk); #1;
    chk({tag, ".pulse_then_idle"}, {rsp_valid, cmd_ready}, 2'b01);
    if (got >= 0 && rd && !exp_err) model_rdata = rd_val;
  endtask

  initial begin
    bit quiet;
    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", cmd_ready, 1);

    // Write addr 0 data 0x55, single-cycle responder
    rise_dly = 1; fall_dly = 1;
    run_txn("wr55", 1'b0, 2'd0, 8'h55, 1'b0, norm_lat(1, 1), 1'b0);

    // Read addr 1 returning 0x41
    rd_val = 8'h41;
    run_txn("rd41", 1'b1, 2'd1, 8'h00, 1'b0, norm_lat(1, 1), 1'b0);

    // cmd_valid held high through the transaction
    rd_val = 8'hC3;
    run_txn("hold_valid", 1'b1, 2'd2, 8'h00, 1'b1, norm_lat(1, 1), 1'b0);

    // Back-to-back write addr 2 then read addr 1
    run_txn("b2b_wr", 1'b0, 2'd2, 8'h78, 1'b0, norm_lat(1, 1), 1'b0);
    rd_val = 8'h9A;
    run_txn("b2b_rd", 1'b1, 2'd1, 8'h00, 1'b0, norm_lat(1, 1), 1'b0);

    // Randomized transactions with random responder delays
    for (int i = 0; i < 20; i++) begin
      logic       rd;
      logic [1:0] a;
      logic [7:0] wd;
      logic       hv;
      rd = 1'($urandom); a = 2'($urandom_range(0, 2)); wd = 8'($urandom);
      hv = 1'($urandom);
      rd_val = 8'($urandom);
      rise_dly = int'($urandom_range(1, 4));
      fall_dly = int'($urandom_range(1, 4));
      run_txn("rand", rd, a, wd, hv, norm_lat(rise_dly, fall_dly), 1'b0);
    end
    rise_dly = 1; fall_dly = 1;

`ifdef WB_HOST_TIMEOUT_EN
    // Ack never rises: timeout in REQ, read data must stay unchanged
    stuck_lo = 1'b1;
    rd_val = 8'hEE;
    run_txn("to_req", 1'b1, 2'd1, 8'h00, 1'b0, T + 1, 1'b1);
    chk("to_req_stb_after", wb_stb, 0);
    stuck_lo = 1'b0;
    // Ack never falls: timeout in RELEASE
    stuck_hi = 1'b1;
    run_txn("to_rel", 1'b0, 2'd0, 8'h3C, 1'b0, 1 + 1 + H + T, 1'b1);
    chk("to_rel_stb_after", wb_stb, 0);
    stuck_hi = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("to_ack_cleared", wb_ack, 0);
`endif

    // Reset while in HOLD: abandoned, no response
    rd_val = 8'h5A;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 2'd1; cmd_wdata = 8'h00;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_in_hold", {wb_stb, wb_clk, wb_ack}, 3'b111);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_state("mid_reset");
    reset = 1'b0;
    quiet = 1;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || wb_stb !== 1'b0) quiet = 0;
    end
    chk("mid_reset_no_rsp", quiet, 1);

    // Still functional after the abandoned transaction
    model_rdata = 8'h00;
    rd_val = 8'h17;
    run_txn("post_reset_rd", 1'b1, 2'd1, 8'h00, 1'b0, norm_lat(1, 1), 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_host.md
WB_HOST -- requirements
Module: wb_host

Interface
REQ-001 SHALL have parameter ACK_HOLD, default 2, cycles wb_clk is held high after wb_ack is first seen (legal 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles to wait on any wb_ack edge (8-bit counter).
REQ-003 SHALL have ports:
  clk  in  1  sole clock; all logic on rising edge
  reset  in  1  synchronous, active-high
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
  cmd_read  in  1  1 = read, 0 = write
  cmd_addr  in  2  register address (0 TX, 1 RX, 2 freq divider)
  cmd_wdata  in  8  write data
  rsp_valid  out  1  one-cycle response pulse
  rsp_rdata  out  8  read data, valid with rsp_valid
  rsp_err  out  1  timeout flag, valid with rsp_valid
  wb_addr  out  2  bus address
  wb_data_out  out  8  bus write data
  wb_data_in  in  8  bus read data
  wb_we  out  1  bus direction: 0 = write, 1 = read
  wb_clk  out  1  bus phase strobe
  wb_stb  out  1  bus select
  wb_ack  in  1  responder acknowledge

Function
REQ-004 SHALL implement states IDLE, REQ, HOLD, RELEASE, RESP.
REQ-005 IDLE: cmd_ready=1; on cmd_valid, SHALL register addr/data, drive wb_we=cmd_read, wb_stb=1, wb_clk=1, cmd_ready=0, go REQ next cycle.
REQ-006 REQ: SHALL hold all bus outputs stable; on wb_ack=1 go HOLD with hold counter cleared.
REQ-007 HOLD: SHALL keep wb_clk=1 for ACK_HOLD cycles; on final HOLD cycle, for reads, capture wb_data_in into rsp_rdata, then go RELEASE.
REQ-008 RELEASE: SHALL drive wb_clk=0, wb_stb=1; on wb_ack=0 drive wb_stb=0 and go RESP.
REQ-009 RESP: SHALL assert rsp_valid for exactly one cycle, then IDLE; writes SHALL leave rsp_rdata unchanged.
REQ-010 Command-to-rsp_valid latency with wb_ack responding in one cycle per edge SHALL be 4+ACK_HOLD cycles.
REQ-011 cmd_valid while not IDLE SHALL be ignored (no queuing); cmd_ready SHALL equal (state==IDLE).
REQ-012 wb_ack already high on entering REQ SHALL be treated as a valid acknowledge (no edge detection).
REQ-013 rsp_valid and a new cmd acceptance SHALL never coincide; minimum command spacing is one IDLE cycle.
REQ-014 wb_data_out SHALL be 0 on reads.

Reset
REQ-015 reset SHALL force IDLE and, in the next cycle, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, wb_stb=0, wb_clk=0, wb_we=1, wb_addr=0, wb_data_out=0, counters 0.
REQ-016 reset mid-transaction SHALL abandon it without issuing rsp_valid.

Configuration
REQ-017 Macro WB_HOST_TIMEOUT_EN SHALL gate the watchdog.
REQ-018 With WB_HOST_TIMEOUT_EN: counter SHALL clear on entering REQ or RELEASE and increment each cycle there; reaching TIMEOUT_CYCLES in REQ SHALL go RELEASE with timeout flag set; in RELEASE SHALL drop wb_stb and go RESP; RESP SHALL then report rsp_err=1, rsp_rdata unchanged.
REQ-019 Without WB_HOST_TIMEOUT_EN: no counter, REQ/RELEASE wait indefinitely, rsp_err SHALL be constant 0.

Verification
REQ-020 Write addr 0 data 0x55, responder acks next cycle -> wb_we=0, wb_data_out=0x55 while wb_stb=1, rsp_valid after 6 cycles, rsp_err=0.
REQ-021 Read addr 1, responder returns 0x41 by ack+1 -> rsp_rdata=0x41, wb_we=1, wb_clk high exactly ACK_HOLD cycles after ack.
REQ-022 cmd_valid held high during a transaction -> exactly one bus transaction per IDLE acceptance, no extra rsp_valid.
REQ-023 Macro defined, wb_ack stuck 0 -> rsp_valid with rsp_err=1 after ~TIMEOUT_CYCLES+3 cycles, wb_stb=0 after.
REQ-024 reset asserted in HOLD -> next cycle all outputs at reset values, no rsp_valid.
REQ-025 Write addr 2 data 78 then read addr 1 back-to-back -> two responses, correct order, wb_addr matches each.
